// File: rtl/dmem_arb.sv
// Two-port data-memory arbiter: one outstanding downstream transaction, one-entry hold slot per port.
// Define DMEM_ARB_RR_EN for round-robin contention; default is fixed priority with port 0 winning.
module dmem_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_cmd,
    input  logic [1:0]      m0_width,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_resp,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_cmd,
    input  logic [1:0]      m1_width,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_resp,
    output logic [XLEN-1:0] m1_rdata,
    output logic            dmem_req,
    output logic            dmem_cmd,
    output logic [1:0]      dmem_width,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic            arb_err
);

    // Control state
    logic busy;
    logic owner;
    logic [1:0] slot_v;
`ifdef DMEM_ARB_RR_EN
    logic last;
`endif

    // Slot payload; qualified by slot_v, so it needs no reset
    logic            slot_cmd   [2];
    logic [1:0]      slot_width [2];
    logic [XLEN-1:0] slot_addr  [2];
    logic [XLEN-1:0] slot_wdata [2];

    // Live request fields gathered per port
    logic [1:0]      req_in;
    logic            cmd_in   [2];
    logic [1:0]      width_in [2];
    logic [XLEN-1:0] addr_in  [2];
    logic [XLEN-1:0] wdata_in [2];

    logic [1:0] owns_pending;
    logic [1:0] drop;
    logic [1:0] live;
    logic [1:0] cand;
    logic [1:0] granted;
    logic       free;
    logic       contention;
    logic       winner;
    logic       grant;
    logic       resp_valid;
    logic       stray_resp;

    always_comb begin
        req_in[0]   = m0_req;
        req_in[1]   = m1_req;
        cmd_in[0]   = m0_cmd;
        cmd_in[1]   = m1_cmd;
        width_in[0] = m0_width;
        width_in[1] = m1_width;
        addr_in[0]  = m0_addr;
        addr_in[1]  = m1_addr;
        wdata_in[0] = m0_wdata;
        wdata_in[1] = m1_wdata;
    end

    // A port that still owns an unanswered transaction may not issue again
    always_comb begin
        resp_valid      = busy & dmem_resp;
        stray_resp      = ~busy & dmem_resp;
        owns_pending[0] = busy & ~owner & ~dmem_resp;
        owns_pending[1] = busy &  owner & ~dmem_resp;
        drop            = req_in & (slot_v | owns_pending);
        live            = req_in & ~drop;
        cand            = slot_v | live;
        free            = ~busy | dmem_resp;
        contention      = cand[0] & cand[1];
    end

    always_comb begin
`ifdef DMEM_ARB_RR_EN
        winner = contention ? ~last : ~cand[0];
`else
        winner = ~cand[0];
`endif
        grant      = free & (cand[0] | cand[1]) & ~rst;
        granted[0] = grant & ~winner;
        granted[1] = grant &  winner;
    end

    // Slotted request takes precedence over the live inputs of the same port
    always_comb begin
        dmem_req = grant;
        if (slot_v[winner]) begin
            dmem_cmd   = slot_cmd[winner];
            dmem_width = slot_width[winner];
            dmem_addr  = slot_addr[winner];
            dmem_wdata = slot_wdata[winner];
        end else begin
            dmem_cmd   = cmd_in[winner];
            dmem_width = width_in[winner];
            dmem_addr  = addr_in[winner];
            dmem_wdata = wdata_in[winner];
        end
    end

    always_comb begin
        m0_resp  = resp_valid & ~owner;
        m1_resp  = resp_valid &  owner;
        m0_rdata = dmem_rdata;
        m1_rdata = dmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            owner   <= 1'b0;
            slot_v  <= 2'b00;
            arb_err <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last    <= 1'b1;
`endif
        end else begin
            busy    <= grant | (busy & ~dmem_resp);
            slot_v  <= cand & ~granted;
            arb_err <= arb_err | stray_resp | (|drop);
            if (grant) begin
                owner <= winner;
`ifdef DMEM_ARB_RR_EN
                last  <= winner;
`endif
            end
        end
    end

    // Capture a live request that did not win this cycle
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (live[i] && !granted[i]) begin
                slot_cmd[i]   <= cmd_in[i];
                slot_width[i] <= width_in[i];
                slot_addr[i]  <= addr_in[i];
                slot_wdata[i] <= wdata_in[i];
            end
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb; expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arb;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req, m0_cmd, m1_req, m1_cmd;
    logic [1:0]      m0_width, m1_width;
    logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic            m0_resp, m1_resp;
    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic            dmem_req, dmem_cmd, dmem_resp;
    logic [1:0]      dmem_width;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            arb_err;

    int n_cmp = 0;
    int n_bad = 0;
    int g_exp [6];
    int r0_t  [6];
    int r1_t  [6];

    always #5 clk = ~clk;

    dmem_arb #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_width(m0_width), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_width(m1_width), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .arb_err(arb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and return all requesters to idle
    task automatic cyc();
        @(negedge clk);
        m0_req = 1'b0; m0_cmd = 1'b0; m0_width = 2'b10; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_cmd = 1'b0; m1_width = 2'b10; m1_addr = '0; m1_wdata = '0;
        dmem_resp = 1'b0; dmem_rdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        #1;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_m0_resp",  32'(m0_resp),  32'd0);
        check("rst_m1_resp",  32'(m1_resp),  32'd0);
        check("rst_arb_err",  32'(arb_err),  32'd0);
        cyc(); rst = 1'b0;

        // Simultaneous requests: port 0 first, port 1 from its slot on the response
        cyc(); m0_req = 1'b1; m0_addr = 32'h10; m1_req = 1'b1; m1_addr = 32'h20; #1;
        check("tie_req0",  32'(dmem_req), 32'd1);
        check("tie_addr0", dmem_addr, 32'h10);
        cyc(); #1;
        check("tie_wait", 32'(dmem_req), 32'd0);
        cyc(); dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111; #1;
        check("tie_m0_resp",  32'(m0_resp), 32'd1);
        check("tie_m0_rdata", m0_rdata, 32'h1111_1111);
        check("tie_req1",     32'(dmem_req), 32'd1);
        check("tie_addr1",    dmem_addr, 32'h20);
        cyc(); dmem_resp = 1'b1; dmem_rdata = 32'h2222_2222; #1;
        check("tie_m1_resp",  32'(m1_resp), 32'd1);
        check("tie_m1_rdata", m1_rdata, 32'h2222_2222);
        check("tie_m0_quiet", 32'(m0_resp), 32'd0);
        check("tie_idle",     32'(dmem_req), 32'd0);

        // Single load with zero-cycle forward and three-cycle downstream latency
        cyc(); m0_req = 1'b1; m0_addr = 32'h100; #1;
        check("ld_req",  32'(dmem_req), 32'd1);
        check("ld_addr", dmem_addr, 32'h100);
        check("ld_cmd",  32'(dmem_cmd), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            check("ld_gap_req",  32'(dmem_req), 32'd0);
            check("ld_gap_resp", 32'(m0_resp), 32'd0);
        end
        cyc(); dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
        check("ld_m0_resp",  32'(m0_resp), 32'd1);
        check("ld_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("ld_m1_resp",  32'(m1_resp), 32'd0);

        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;

        // Continuous contention; each port re-requests on its own response
`ifdef DMEM_ARB_RR_EN
        g_exp = '{0, 1, 0, 1, 0, -1};
        r0_t  = '{1, 1, 0, 1, 0, 0};
        r1_t  = '{1, 0, 1, 0, 0, 0};
`else
        g_exp = '{0, 0, 0, 0, 1, -1};
        r0_t  = '{1, 1, 1, 1, 0, 0};
        r1_t  = '{1, 0, 0, 0, 0, 0};
`endif
        for (int c = 0; c < 6; c++) begin
            cyc();
            m0_req = 1'(r0_t[c]); m0_addr = 32'h200;
            m1_req = 1'(r1_t[c]); m1_addr = 32'h300;
            dmem_resp = (c > 0);
            #1;
            check($sformatf("cont%0d_req", c), 32'(dmem_req), 32'(g_exp[c] >= 0));
            if (g_exp[c] >= 0)
                check($sformatf("cont%0d_addr", c), dmem_addr, (g_exp[c] == 1) ? 32'h300 : 32'h200);
            check($sformatf("cont%0d_m0_resp", c), 32'(m0_resp), 32'(c > 0 && g_exp[(c > 0) ? c - 1 : 0] == 0));
            check($sformatf("cont%0d_m1_resp", c), 32'(m1_resp), 32'(c > 0 && g_exp[(c > 0) ? c - 1 : 0] == 1));
        end

        // Store stream with a response every cycle: no bubble between grants
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (c < 4) begin
                m0_req = 1'b1; m0_cmd = 1'b1;
                m0_addr = 32'h400 + 32'(4 * c); m0_wdata = 32'hA0 + 32'(c);
            end
            dmem_resp = (c > 0);
            #1;
            check($sformatf("st%0d_req", c), 32'(dmem_req), 32'(c < 4));
            if (c < 4) begin
                check($sformatf("st%0d_cmd", c),   32'(dmem_cmd), 32'd1);
                check($sformatf("st%0d_addr", c),  dmem_addr, 32'h400 + 32'(4 * c));
                check($sformatf("st%0d_wdata", c), dmem_wdata, 32'hA0 + 32'(c));
            end
            check($sformatf("st%0d_m0_resp", c), 32'(m0_resp), 32'(c > 0));
        end
        check("st_no_err", 32'(arb_err), 32'd0);

        // Second m1 request while its slot is occupied is dropped and flagged
        cyc(); m0_req = 1'b1; m0_addr = 32'h500; #1;
        check("err_grant0", 32'(dmem_req), 32'd1);
        cyc(); m1_req = 1'b1; m1_addr = 32'h600; #1;
        check("err_slotted", 32'(dmem_req), 32'd0);
        cyc(); m1_req = 1'b1; m1_addr = 32'h700; #1;
        check("err_not_yet", 32'(arb_err), 32'd0);
        cyc(); dmem_resp = 1'b1; #1;
        check("err_set",     32'(arb_err), 32'd1);
        check("err_m0_resp", 32'(m0_resp), 32'd1);
        check("err_addr",    dmem_addr, 32'h600);
        cyc(); dmem_resp = 1'b1; #1;
        check("err_m1_resp", 32'(m1_resp), 32'd1);
        check("err_no_req",  32'(dmem_req), 32'd0);
        cyc(); #1;
        check("err_sticky", 32'(arb_err), 32'd1);
        cyc(); rst = 1'b1; #1;
        check("err_cleared", 32'(arb_err), 32'd0);
        cyc(); rst = 1'b0;

        // Reset in the middle of a transaction, then a late downstream response
        cyc(); m0_req = 1'b1; m0_addr = 32'h800; #1;
        check("mid_grant", 32'(dmem_req), 32'd1);
        cyc(); rst = 1'b1; dmem_resp = 1'b1; #1;
        check("mid_rst_req",  32'(dmem_req), 32'd0);
        check("mid_rst_m0",   32'(m0_resp), 32'd0);
        check("mid_rst_m1",   32'(m1_resp), 32'd0);
        cyc(); rst = 1'b0; dmem_resp = 1'b1; #1;
        check("late_m0_resp", 32'(m0_resp), 32'd0);
        check("late_m1_resp", 32'(m1_resp), 32'd0);
        check("late_err_pre", 32'(arb_err), 32'd0);
        cyc(); #1;
        check("late_err", 32'(arb_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
